ber_aligner: RTL and testbench

Delay-search front end placed between the reference PRBS9 generator / receive path and the BER counter. It buffers the reference sequence and searches for the delay at which the received bit stream matches it. Once locked, it presents a time-aligned reference bit, the received bit and a qualifying valid strobe to the BER counter. It also reports the lock state and the detected delay.

---
 rtl/ber_aligner_pkg.sv | 16 +
 rtl/ber_aligner_ref_delay_line.sv | 31 +++
 rtl/ber_aligner.sv | 135 +++++++++++++
 tb/tb_ber_aligner.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ber_aligner_pkg.sv
// ber_aligner shared types and parameter defaults.
// State encoding for the delay-search FSM.
package ber_aligner_pkg;

  localparam int MAX_DELAY_DEF = 32;
  localparam int WINDOW_DEF    = 64;
  localparam int ERR_THR_DEF   = 2;
  localparam int LOSS_THR_DEF  = 8;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/ber_aligner_ref_delay_line.sv
// ref_delay_line: valid-gated reference shift register with tap mux.
// Ports: clock, i_reset (sync, active-low), i_valid, i_ref, i_sel -> o_tap.
module ref_delay_line #(
  parameter int  DEPTH = 32,
  localparam int SW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clock,
  input  logic          i_reset,
  input  logic          i_valid,
  input  logic          i_ref,
  input  logic [SW-1:0] i_sel,
  output logic          o_tap
);

  // sr[k] holds the reference k valid samples ago
  logic [DEPTH-1:1] sr;
  logic [DEPTH-1:0] taps;

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      sr <= '0;
    end else if (i_valid) begin
      sr <= {sr[DEPTH-2:1], i_ref};
    end
  end

  // tap 0 is the live input, so delay 0 needs no storage
  assign taps  = {sr, i_ref};
  assign o_tap = taps[i_sel];

endmodule

// File: rtl/ber_aligner.sv
// ber_aligner: searches the rx-vs-reference delay, then feeds the BER counter.
// Ports: clock, i_reset (sync, active-low), i_rx, i_ref, i_valid in;
//        o_rx, o_ref, o_valid, o_locked, o_delay out.
// Build option: BER_ALIGNER_RELOCK_EN enables loss-of-lock and re-search.
module ber_aligner
  import ber_aligner_pkg::*;
#(
  parameter int  MAX_DELAY = MAX_DELAY_DEF,
  parameter int  WINDOW    = WINDOW_DEF,
  parameter int  ERR_THR   = ERR_THR_DEF,
  parameter int  LOSS_THR  = LOSS_THR_DEF,
  localparam int DW        = $clog2(MAX_DELAY),
  localparam int WW        = $clog2(WINDOW),
  localparam int EW        = $clog2(WINDOW + 1)
) (
  input  logic          clock,
  input  logic          i_reset,
  input  logic          i_rx,
  input  logic          i_ref,
  input  logic          i_valid,
  output logic          o_rx,
  output logic          o_ref,
  output logic          o_valid,
  output logic          o_locked,
  output logic [DW-1:0] o_delay
);

  if (MAX_DELAY < 2 || WINDOW < 2 ||
      ERR_THR < 0 || LOSS_THR < 0) begin : g_bad_cfg
    $error("ber_aligner: invalid parameters");
  end

  state_t        state;
  logic [DW-1:0] fill_cnt;
  logic [WW-1:0] win_cnt;
  logic [EW-1:0] err_cnt;
  logic [EW-1:0] err_tot;
  logic          tap;
  logic          err;
  logic          win_end;
  logic          err_full;

  ref_delay_line #(
    .DEPTH (MAX_DELAY)
  ) u_dly (
    .clock   (clock),
    .i_reset (i_reset),
    .i_valid (i_valid),
    .i_ref   (i_ref),
    .i_sel   (o_delay),
    .o_tap   (tap)
  );

  assign err      = i_rx ^ tap;
  assign win_end  = (win_cnt == WW'(WINDOW - 1));
  assign err_full = (err_cnt == EW'(WINDOW));

  // error total including the current sample, saturating at WINDOW
  assign err_tot = (err && !err_full) ?
                   err_cnt + EW'(1) : err_cnt;

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      state    <= ST_FILL;
      fill_cnt <= '0;
      win_cnt  <= '0;
      err_cnt  <= '0;
      o_delay  <= '0;
      o_locked <= 1'b0;
      o_valid  <= 1'b0;
      o_rx     <= 1'b0;
      o_ref    <= 1'b0;
    end else begin
      // qualifies the sample taken now, judged by the pre-edge state
      o_valid <= i_valid && (state == ST_LOCKED);
      if (i_valid) begin
        o_rx  <= i_rx;
        o_ref <= tap;
        unique case (state)
          ST_FILL: begin
            if (fill_cnt == DW'(MAX_DELAY - 1)) begin
              state    <= ST_SEARCH;
              fill_cnt <= '0;
              o_delay  <= '0;
              win_cnt  <= '0;
              err_cnt  <= '0;
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
          ST_SEARCH: begin
            if (win_end) begin
              win_cnt <= '0;
              err_cnt <= '0;
              if (err_tot <= EW'(ERR_THR)) begin
                state    <= ST_LOCKED;
                o_locked <= 1'b1;
              end else if (o_delay == DW'(MAX_DELAY - 1)) begin
                o_delay <= '0;
              end else begin
                o_delay <= o_delay + 1'b1;
              end
            end else begin
              win_cnt <= win_cnt + 1'b1;
              err_cnt <= err_tot;
            end
          end
          ST_LOCKED: begin
`ifdef BER_ALIGNER_RELOCK_EN
            if (win_end) begin
              win_cnt <= '0;
              err_cnt <= '0;
              if (err_tot > EW'(LOSS_THR)) begin
                state    <= ST_SEARCH;
                o_locked <= 1'b0;
                o_delay  <= '0;
              end
            end else begin
              win_cnt <= win_cnt + 1'b1;
              err_cnt <= err_tot;
            end
`else
            // lock is sticky; counters stay idle
            state <= ST_LOCKED;
`endif
          end
          default: begin
            state <= ST_FILL;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ber_aligner.sv
// tb_ber_aligner: directed vectors for ber_aligner.
// PRBS9 reference, rx formed from a delayed copy of the reference.
module tb_ber_aligner;

  logic       clock = 1'b0;
  logic       i_reset;
  logic       i_rx;
  logic       i_ref;
  logic       i_valid;
  logic       o_rx;
  logic       o_ref;
  logic       o_valid;
  logic       o_locked;
  logic [4:0] o_delay;

  always #5 clock = ~clock;

  ber_aligner dut (
    .clock    (clock),
    .i_reset  (i_reset),
    .i_rx     (i_rx),
    .i_ref    (i_ref),
    .i_valid  (i_valid),
    .o_rx     (o_rx),
    .o_ref    (o_ref),
    .o_valid  (o_valid),
    .o_locked (o_locked),
    .o_delay  (o_delay)
  );

  int       vec_n = 0;
  int       bad_n = 0;
  logic [8:0] lfsr = 9'h1FF;
  bit       hist [64];
  int       g = 0;
  int       vcnt = 0;
  int       d_rx = 0;
  bit       stuck = 1'b0;

  typedef struct {
    int dly;
    bit stk;
    int budget;
    int exp_lock;
    int exp_delay;
  } vec_t;

  vec_t tab [4];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    vec_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic sample(input bit v);
    bit r;
    if (v) begin
      r = lfsr[8] ^ lfsr[4];
      lfsr = {lfsr[7:0], r};
      hist[g & 63] = r;
      i_ref = r;
      if (stuck) i_rx = 1'b0;
      else if (g >= d_rx) i_rx = hist[(g - d_rx) & 63];
      else i_rx = 1'b0;
      g++;
      vcnt++;
    end else begin
      i_ref = 1'($urandom);
      i_rx  = 1'($urandom);
    end
    i_valid = v;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input string name);
    i_reset = 1'b0;
    i_valid = 1'b0;
    @(posedge clock);
    #1;
    check(name, {23'd0, o_rx, o_ref, o_valid,
                 o_locked, o_delay}, 0);
    i_reset = 1'b1;
    vcnt = 0;
  endtask

  task automatic run_to_lock(input int budget,
                             output int lock_at,
                             output int early_v,
                             output int max_d);
    lock_at = -1;
    early_v = 0;
    max_d   = 0;
    for (int i = 0; i < budget; i++) begin
      sample(1'b1);
      if (o_valid) early_v++;
      if (int'(o_delay) > max_d) max_d = int'(o_delay);
      if (o_locked) begin
        lock_at = vcnt;
        break;
      end
    end
  endtask

  initial begin
    int la, ev, md, nv, nm, cnt, drop, badov;
    i_reset = 1'b0;
    i_valid = 1'b0;
    i_rx    = 1'b0;
    i_ref   = 1'b0;

    tab[0] = '{11, 1'b0, 900,  800,  11};
    tab[1] = '{0,  1'b0, 200,  96,   0};
    tab[2] = '{31, 1'b0, 2200, 2080, 31};
    tab[3] = '{5,  1'b1, 2144, -1,   1};

    foreach (tab[t]) begin
      d_rx  = tab[t].dly;
      stuck = tab[t].stk;
      do_reset("reset_state");
      run_to_lock(tab[t].budget, la, ev, md);
      check("lock_sample", la, tab[t].exp_lock);
      check("delay", {27'd0, o_delay}, tab[t].exp_delay);
      check("valid_before_lock", ev, 0);
      if (tab[t].exp_lock >= 0) begin
        nv = 0;
        nm = 0;
        for (int i = 0; i < 200; i++) begin
          sample(1'b1);
          if (o_valid) nv++;
          if (o_valid && (o_rx != o_ref)) nm++;
        end
        check("valid_count_locked", nv, 200);
        check("ber_errors", nm, 0);
      end else begin
        check("delay_walk_max", md, 31);
      end
    end

    // delay change while locked
    stuck = 1'b0;
    d_rx  = 11;
    do_reset("reset_state_chg");
    run_to_lock(900, la, ev, md);
    check("chg_lock_sample", la, 800);
    d_rx = 5;
`ifdef BER_ALIGNER_RELOCK_EN
    drop = -1;
    for (int i = 1; i <= 200; i++) begin
      sample(1'b1);
      if (!o_locked) begin
        drop = i;
        break;
      end
    end
    check("drop_within_2_windows",
          (drop > 0 && drop <= 128) ? 1 : 0, 1);
    run_to_lock(600, la, ev, md);
    check("relock_sample", la, 1248);
    check("relock_delay", {27'd0, o_delay}, 5);
`else
    cnt = 0;
    nv  = 0;
    for (int i = 0; i < 640; i++) begin
      sample(1'b1);
      if (!o_locked) cnt++;
      if (o_valid) nv++;
    end
    check("sticky_unlocked_cycles", cnt, 0);
    check("sticky_delay", {27'd0, o_delay}, 11);
    check("sticky_valid_count", nv, 640);
`endif

    // i_valid toggling every other cycle
    d_rx = 11;
    do_reset("reset_state_tog");
    la = -1;
    badov = 0;
    for (int c = 0; c < 1700; c++) begin
      sample(c % 2 == 1);
      if ((c % 2 == 0) && o_valid) badov++;
      if (o_locked) begin
        la = vcnt;
        break;
      end
    end
    check("tog_lock_sample", la, 800);
    check("tog_delay", {27'd0, o_delay}, 11);
    nv = 0;
    for (int c = 0; c < 100; c++) begin
      sample(c % 2 == 1);
      if ((c % 2 == 0) && o_valid) badov++;
      if (o_valid) nv++;
    end
    check("tog_valid_count", nv, 50);
    check("tog_valid_on_idle", badov, 0);

    // reset pulse during search at delay 7
    do_reset("reset_state_mid");
    for (int i = 0; i < 600; i++) begin
      sample(1'b1);
      if (o_delay == 5'd7) break;
    end
    check("mid_reach_delay7", {27'd0, o_delay}, 7);
    for (int i = 0; i < 10; i++) sample(1'b1);
    i_reset = 1'b0;
    sample(1'b1);
    check("mid_reset_outputs", {23'd0, o_rx, o_ref,
          o_valid, o_locked, o_delay}, 0);
    i_reset = 1'b1;
    vcnt = 0;
    run_to_lock(900, la, ev, md);
    check("mid_relock_sample", la, 800);
    check("mid_relock_delay", {27'd0, o_delay}, 11);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_n, bad_n);
    $finish;
  end

endmodule
